fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 122 ++++++++++++
 tb/tb_fetch_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Multi-cycle instruction fetch unit: FETCH, WAIT, DECODE, EXEC.
// Owns the PC, the instruction register and the retired-instruction count.
//
// Ports:
//   Clk, Rst          clock; synchronous active-low reset
//   imem_addr         instruction memory byte address (always equal to pc)
//   imem_req          registered read request, high while in WAIT
//   imem_ack          read data valid on imem_rdata (sampled in WAIT only)
//   imem_rdata        instruction word from memory
//   instr, opcode     instruction register and its [31:26] field
//   instr_valid       one-cycle pulse while in DECODE
//   Branch/Jump/Zero  next-PC controls, sampled in EXEC on exec_done
//   exec_done         current instruction finished (accepted in EXEC only)
//   pc                address of the current instruction
//   retired           count of completed instructions, wraps at 16 bits
module fetch_unit (
    input  logic        Clk,
    input  logic        Rst,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic        instr_valid,
    input  logic        Branch,
    input  logic        Jump,
    input  logic        Zero,
    input  logic        exec_done,
    output logic [31:0] pc,
    output logic [15:0] retired
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_DECODE,
        S_EXEC
    } state_t;

    state_t      state;
    state_t      state_n;
    logic [31:0] pc_n;
    logic [31:0] ir_n;
    logic        req_n;
    logic        valid_n;
    logic [15:0] ret_n;

    logic [31:0] pc_plus4;
    logic [31:0] br_target;
    logic [31:0] jmp_target;

    assign pc_plus4   = pc + 32'd4;
    assign br_target  = pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00};
    assign jmp_target = {pc_plus4[31:28], instr[25:0], 2'b00};

    assign imem_addr = pc;
    assign opcode    = instr[31:26];

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state       <= S_FETCH;
            pc          <= 32'd0;
            imem_req    <= 1'b0;
            instr       <= 32'd0;
            instr_valid <= 1'b0;
            retired     <= 16'd0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            imem_req    <= req_n;
            instr       <= ir_n;
            instr_valid <= valid_n;
            retired     <= ret_n;
        end
    end

    // Next values for every registered output; all outputs hold by default.
    always_comb begin
        state_n = state;
        pc_n    = pc;
        ir_n    = instr;
        req_n   = imem_req;
        valid_n = 1'b0;
        ret_n   = retired;
        unique case (state)
            S_FETCH: begin
                req_n   = 1'b1;
                state_n = S_WAIT;
            end
            S_WAIT: begin
                if (imem_ack) begin
                    ir_n    = imem_rdata;
                    req_n   = 1'b0;
                    valid_n = 1'b1;
                    state_n = S_DECODE;
                end
            end
            S_DECODE: begin
                state_n = S_EXEC;
            end
            S_EXEC: begin
                if (exec_done) begin
                    // Jump outranks a taken branch.
                    if (Jump) begin
                        pc_n = jmp_target;
                    end else if (Branch && Zero) begin
                        pc_n = br_target;
                    end else begin
                        pc_n = pc_plus4;
                    end
                    ret_n   = retired + 16'd1;
                    state_n = S_FETCH;
                end
            end
            default: begin
                state_n = S_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: table of instructions run back to back,
// then hand-written reset and counter-wrap sequences.
module tb_fetch_unit;

    logic        Clk;
    logic        Rst;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic        instr_valid;
    logic        Branch;
    logic        Jump;
    logic        Zero;
    logic        exec_done;
    logic [31:0] pc;
    logic [15:0] retired;

    int n_tests;
    int n_fail;

    logic [31:0] exp_ir;
    logic [15:0] exp_ret;

    fetch_unit dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .imem_addr   (imem_addr),
        .imem_req    (imem_req),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .opcode      (opcode),
        .instr_valid (instr_valid),
        .Branch      (Branch),
        .Jump        (Jump),
        .Zero        (Zero),
        .exec_done   (exec_done),
        .pc          (pc),
        .retired     (retired)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0] rdata;
        logic        b;
        logic        j;
        logic        z;
        int          ack_dly;
        int          done_dly;
        logic [31:0] pc_cur;
        logic [5:0]  op;
        logic [31:0] pc_next;
    } vec_t;

    vec_t tv[9];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Starts at a negedge in FETCH, ends at a negedge in EXEC.
    task automatic do_fetch(input logic [31:0] rd, input int ad,
                            input logic [31:0] epc, input logic [5:0] eop);
        chk("fetch_req", {31'd0, imem_req}, 32'd0);
        chk("fetch_addr", imem_addr, epc);
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEADBEEF;
        @(negedge Clk);
        imem_ack  = 1'b0;
        exec_done = 1'b1;
        Jump      = 1'b1;
        chk("wait_req", {31'd0, imem_req}, 32'd1);
        chk("wait_ir", instr, exp_ir);
        for (int k = 0; k < ad; k++) begin
            @(negedge Clk);
            chk("stall_req", {31'd0, imem_req}, 32'd1);
            chk("stall_ir", instr, exp_ir);
            chk("stall_pc", pc, epc);
        end
        exec_done  = 1'b0;
        Jump       = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = rd;
        @(negedge Clk);
        imem_ack = 1'b0;
        exp_ir   = rd;
        chk("dec_instr", instr, exp_ir);
        chk("dec_opcode", {26'd0, opcode}, {26'd0, eop});
        chk("dec_valid", {31'd0, instr_valid}, 32'd1);
        chk("dec_req", {31'd0, imem_req}, 32'd0);
        chk("dec_addr", imem_addr, epc);
        @(negedge Clk);
        chk("exec_valid", {31'd0, instr_valid}, 32'd0);
    endtask

    // Starts at a negedge in EXEC, ends at a negedge in FETCH.
    task automatic do_exec(input logic b, input logic j, input logic z,
                           input int dd, input logic [31:0] epc,
                           input logic [31:0] enext);
        for (int k = 0; k < dd; k++) begin
            imem_ack   = 1'b1;
            imem_rdata = 32'hFFFFFFFF;
            Branch     = 1'b1;
            Jump       = 1'b1;
            Zero       = 1'b1;
            @(negedge Clk);
            chk("exstall_pc", pc, epc);
            chk("exstall_ir", instr, exp_ir);
            chk("exstall_ret", {16'd0, retired}, {16'd0, exp_ret});
        end
        imem_ack  = 1'b0;
        Branch    = b;
        Jump      = j;
        Zero      = z;
        exec_done = 1'b1;
        @(negedge Clk);
        exec_done = 1'b0;
        Branch    = 1'b0;
        Jump      = 1'b0;
        Zero      = 1'b0;
        exp_ret   = exp_ret + 16'd1;
        chk("next_pc", pc, enext);
        chk("retired", {16'd0, retired}, {16'd0, exp_ret});
        chk("post_req", {31'd0, imem_req}, 32'd0);
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        Rst        = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        Branch     = 1'b0;
        Jump       = 1'b0;
        Zero       = 1'b0;
        exec_done  = 1'b0;
        exp_ir     = 32'd0;
        exp_ret    = 16'd0;

        //           rdata         b     j     z    ad dd pc_cur        op     pc_next
        tv[0] = '{32'h012A4020, 1'b0, 1'b0, 1'b0, 0, 0, 32'h00000000, 6'h00, 32'h00000004};
        tv[1] = '{32'h8D090004, 1'b0, 1'b0, 1'b0, 0, 0, 32'h00000004, 6'h23, 32'h00000008};
        tv[2] = '{32'h1109FFFE, 1'b1, 1'b0, 1'b1, 0, 0, 32'h00000008, 6'h04, 32'h00000004};
        tv[3] = '{32'h1109FFFE, 1'b1, 1'b0, 1'b0, 5, 3, 32'h00000004, 6'h04, 32'h00000008};
        tv[4] = '{32'h08000010, 1'b1, 1'b1, 1'b1, 0, 0, 32'h00000008, 6'h02, 32'h00000040};
        tv[5] = '{32'h08000000, 1'b0, 1'b1, 1'b0, 1, 1, 32'h00000040, 6'h02, 32'h00000000};
        tv[6] = '{32'h1000FFFE, 1'b1, 1'b0, 1'b1, 0, 0, 32'h00000000, 6'h04, 32'hFFFFFFFC};
        tv[7] = '{32'h00000000, 1'b0, 1'b0, 1'b0, 0, 0, 32'hFFFFFFFC, 6'h00, 32'h00000000};
        tv[8] = '{32'h0C000003, 1'b1, 1'b0, 1'b0, 2, 0, 32'h00000000, 6'h03, 32'h00000004};

        repeat (2) @(negedge Clk);
        chk("rst_pc", pc, 32'd0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_retired", {16'd0, retired}, 32'd0);
        Rst = 1'b1;

        for (int i = 0; i < 9; i++) begin
            do_fetch(tv[i].rdata, tv[i].ack_dly, tv[i].pc_cur, tv[i].op);
            do_exec(tv[i].b, tv[i].j, tv[i].z, tv[i].done_dly,
                    tv[i].pc_cur, tv[i].pc_next);
        end

        // Retired counter wrap: preload the count instead of running 64K ops.
        dut.retired = 16'hFFFF;
        exp_ret     = 16'hFFFF;
        do_fetch(32'h012A4020, 0, 32'h00000004, 6'h00);
        do_exec(1'b0, 1'b0, 1'b0, 0, 32'h00000004, 32'h00000008);
        chk("ret_wrap", {16'd0, retired}, 32'd0);

        // Reset while waiting on memory.
        @(negedge Clk);
        chk("mw_req", {31'd0, imem_req}, 32'd1);
        Rst = 1'b0;
        @(negedge Clk);
        Rst     = 1'b1;
        exp_ir  = 32'd0;
        exp_ret = 16'd0;
        chk("mw_pc", pc, 32'd0);
        chk("mw_req0", {31'd0, imem_req}, 32'd0);
        chk("mw_ret", {16'd0, retired}, 32'd0);
        chk("mw_instr", instr, 32'd0);
        do_fetch(32'h012A4020, 0, 32'h00000000, 6'h00);
        do_exec(1'b0, 1'b0, 1'b0, 0, 32'h00000000, 32'h00000004);

        // Reset in EXEC with exec_done and Jump asserted on that edge.
        do_fetch(32'h8D090004, 0, 32'h00000004, 6'h23);
        exec_done = 1'b1;
        Jump      = 1'b1;
        Rst       = 1'b0;
        @(negedge Clk);
        exec_done = 1'b0;
        Jump      = 1'b0;
        Rst       = 1'b1;
        exp_ir    = 32'd0;
        exp_ret   = 16'd0;
        chk("me_pc", pc, 32'd0);
        chk("me_req", {31'd0, imem_req}, 32'd0);
        chk("me_ret", {16'd0, retired}, 32'd0);
        chk("me_valid", {31'd0, instr_valid}, 32'd0);
        do_fetch(32'h8D090004, 1, 32'h00000000, 6'h23);
        do_exec(1'b0, 1'b0, 1'b0, 0, 32'h00000000, 32'h00000004);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
